lcd_timed_controller: RTL and testbench

- Avalon-MM slave driving an HD44780-class character LCD with generated bus timing: address setup, E pulse width, hold/recovery.
- Replaces the direct strobe-to-pin slave: transfers stretch via waitrequest until the LCD cycle completes.
- Supports 8-bit or 4-bit (two-nibble) LCD bus mode.
- Sits between the Nios system interconnect and the top-level LCD pins; the top level builds the tristate from the out/oe/in split.

---
 rtl/lcd_ctrl_pkg.sv | 17 +
 rtl/lcd_phase_counter.sv | 32 +++
 rtl/lcd_timed_controller.sv | 169 ++++++++++++++++
 tb/tb_lcd_timed_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the timed HD44780 LCD controller.
//   state_t : controller FSM states
//   RS_BIT / RW_BIT : positions of RS and RW within the Avalon address
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } state_t;

  localparam int unsigned RS_BIT = 1;
  localparam int unsigned RW_BIT = 0;

endpackage

// File: rtl/lcd_phase_counter.sv
// Loadable down-counter timing the setup, pulse and hold phases.
//   clk, reset  : clock, async active-high reset
//   load        : load load_value (wins over dec)
//   load_value  : phase length minus one
//   dec         : count down, saturating at zero
//   count       : current value
//   zero_c      : combinational count==0 flag
module lcd_phase_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero_c
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/lcd_timed_controller.sv
// Avalon-MM slave generating HD44780 bus cycles (setup, E pulse, hold),
// stalling the master with waitrequest until the LCD cycle completes.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   address[1]=RS, address[0]=RW, read, write, writedata : Avalon request
//   readdata, waitrequest      : Avalon response (waitrequest combinational)
//   LCD_E, LCD_RS, LCD_RW      : LCD control pins
//   LCD_data_out/oe/in         : split LCD data bus, tristate built above
module lcd_timed_controller
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned BUS_W = 8,
  parameter int unsigned T_AS  = 2,
  parameter int unsigned T_PW  = 12,
  parameter int unsigned T_H   = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [7:0]       writedata,
  output logic [7:0]       readdata,
  output logic             waitrequest,
  output logic             LCD_E,
  output logic             LCD_RS,
  output logic             LCD_RW,
  output logic [BUS_W-1:0] LCD_data_out,
  output logic             LCD_data_oe,
  input  logic [BUS_W-1:0] LCD_data_in
);

  localparam bit NIBBLE = (BUS_W == 4);

  state_t           state, state_n;
  logic             e_n, rs_n, rw_n, oe_n, done, done_n;
  logic [BUS_W-1:0] dout_n;
  logic [7:0]       rdata_n;
  logic [3:0]       lo_nib, lo_nib_n;
  logic             is_read, is_read_n;
  logic             nibble, nibble_n;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;

  lcd_phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_val),
    .dec        (cnt_dec),
    .count      (cnt),
    .zero_c     (cnt_zero)
  );

  // Master stalls until the registered done flag is seen.
  assign waitrequest = (read | write) & ~done;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      LCD_E        <= 1'b0;
      LCD_RS       <= 1'b0;
      LCD_RW       <= 1'b1;
      LCD_data_oe  <= 1'b0;
      LCD_data_out <= '0;
      readdata     <= '0;
      lo_nib       <= '0;
      is_read      <= 1'b0;
      nibble       <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      LCD_E        <= e_n;
      LCD_RS       <= rs_n;
      LCD_RW       <= rw_n;
      LCD_data_oe  <= oe_n;
      LCD_data_out <= dout_n;
      readdata     <= rdata_n;
      lo_nib       <= lo_nib_n;
      is_read      <= is_read_n;
      nibble       <= nibble_n;
      done         <= done_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    e_n       = LCD_E;
    rs_n      = LCD_RS;
    rw_n      = LCD_RW;
    oe_n      = LCD_data_oe;
    dout_n    = LCD_data_out;
    rdata_n   = readdata;
    lo_nib_n  = lo_nib;
    is_read_n = is_read;
    nibble_n  = nibble;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;

    case (state)
      IDLE: begin
        if (read | write) begin
          // A simultaneous read and write is serviced as a write.
          rs_n      = address[RS_BIT];
          rw_n      = address[RW_BIT];
          oe_n      = write & ~address[RW_BIT];
          is_read_n = ~write;
          lo_nib_n  = writedata[3:0];
          dout_n    = NIBBLE ? BUS_W'(writedata[7:4]) : BUS_W'(writedata);
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(T_AS - 1);
          state_n   = SETUP;
        end
      end
      SETUP: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          e_n      = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(T_PW - 1);
          state_n  = PULSE;
        end
      end
      PULSE: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          // Sample on the last E-high cycle; nibble 0 is the high half.
          if (is_read) begin
            if (!NIBBLE)     rdata_n = 8'(LCD_data_in);
            else if (nibble) rdata_n = {readdata[7:4], 4'(LCD_data_in)};
            else             rdata_n = {4'(LCD_data_in), readdata[3:0]};
          end
          e_n      = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(T_H - 1);
          state_n  = HOLD;
        end
      end
      HOLD: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          if (NIBBLE && !nibble) begin
            nibble_n = 1'b1;
            dout_n   = BUS_W'(lo_nib);
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(T_AS - 1);
            state_n  = SETUP;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        oe_n     = 1'b0;
        rw_n     = 1'b1;
        nibble_n = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase

    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_lcd_timed_controller.sv
// Self-checking bench: an 8-bit and a 4-bit controller side by side, each
// transfer checked cycle by cycle against a phase-arithmetic timing model.
module tb_lcd_timed_controller;

  localparam int T_AS = 2;
  localparam int T_PW = 12;
  localparam int T_H  = 10;
  localparam int PH   = T_AS + T_PW + T_H;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] address;
  logic [7:0] writedata;
  logic       rd [2];
  logic       wr [2];
  logic [7:0] rdata [2];
  logic [7:0] din [2];
  logic [1:0] wreq, e, rs, rw, oe;
  logic [7:0] dout8;
  logic [3:0] dout4;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_rd [2];
  int         gcyc = 0;
  int         last_fall [2];
  logic       last_e [2];

  always #5 clk = ~clk;

  lcd_timed_controller #(.BUS_W(8)) dut8 (
    .clk(clk), .reset(reset), .address(address), .read(rd[0]), .write(wr[0]),
    .writedata(writedata), .readdata(rdata[0]), .waitrequest(wreq[0]),
    .LCD_E(e[0]), .LCD_RS(rs[0]), .LCD_RW(rw[0]), .LCD_data_out(dout8),
    .LCD_data_oe(oe[0]), .LCD_data_in(din[0])
  );

  lcd_timed_controller #(.BUS_W(4)) dut4 (
    .clk(clk), .reset(reset), .address(address), .read(rd[1]), .write(wr[1]),
    .writedata(writedata), .readdata(rdata[1]), .waitrequest(wreq[1]),
    .LCD_E(e[1]), .LCD_RS(rs[1]), .LCD_RW(rw[1]), .LCD_data_out(dout4),
    .LCD_data_oe(oe[1]), .LCD_data_in(din[1][3:0])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // One Avalon transfer on DUT sel; entered and left #1 after a posedge.
  task automatic xfer(input int sel, input logic r, input logic w,
                      input logic [1:0] addr, input logic [7:0] wdata);
    int         npass;
    int         done_k;
    int         q;
    int         ph;
    logic       exp_e;
    logic       drive;
    logic [7:0] exp_d;
    logic [7:0] got_d;
    logic [3:0] samp [2];
    logic [7:0] samp8;
    npass  = (sel == 1) ? 2 : 1;
    done_k = npass * PH + 1;
    drive  = w & ~addr[0];
    samp8  = '0;
    samp[0] = '0;
    samp[1] = '0;
    address = addr;
    writedata = wdata;
    rd[sel] = r;
    wr[sel] = w;
    for (int k = 0; k <= done_k; k++) begin
      din[0] = 8'($urandom);
      din[1] = 8'($urandom);
      if (k > 0) begin
        address   = 2'($urandom);
        writedata = 8'($urandom);
      end
      @(negedge clk);
      gcyc++;
      q  = (k > 0) ? (k - 1) / PH : 0;
      ph = (k > 0) ? (k - 1) % PH : 0;
      exp_e = (k > 0) && (q < npass) && (ph >= T_AS) && (ph < T_AS + T_PW);
      check("lcd_e", 32'(e[sel]), 32'(exp_e));
      check("waitrequest", 32'(wreq[sel]), 32'(k != done_k));
      if (k > 0) begin
        check("lcd_rs", 32'(rs[sel]), 32'(addr[1]));
        check("lcd_rw", 32'(rw[sel]), 32'(addr[0]));
        check("lcd_oe", 32'(oe[sel]), 32'(drive));
        if (drive) begin
          if (sel == 0) exp_d = wdata;
          else          exp_d = (q == 0) ? {4'h0, wdata[7:4]} : {4'h0, wdata[3:0]};
          got_d = (sel == 0) ? dout8 : {4'h0, dout4};
          check("lcd_data", 32'(got_d), 32'(exp_d));
        end
        // Last E-high cycle: the pins are captured at its closing edge.
        if (q < npass && ph == T_AS + T_PW - 1) begin
          if (sel == 0) samp8 = din[0];
          else          samp[q] = din[1][3:0];
        end
      end
      if (e[sel] && !last_e[sel] && last_fall[sel] >= 0)
        check("e_gap", 32'((gcyc - last_fall[sel]) >= T_H + T_AS), 32'(1));
      if (!e[sel] && last_e[sel]) last_fall[sel] = gcyc;
      last_e[sel] = e[sel];
      if (k == done_k) begin
        if (!w) exp_rd[sel] = (sel == 0) ? samp8 : {samp[0], samp[1]};
        check("readdata", 32'(rdata[sel]), 32'(exp_rd[sel]));
      end
      @(posedge clk);
      #1;
    end
    rd[sel] = 1'b0;
    wr[sel] = 1'b0;
  endtask

  // Abort a write five cycles into its pulse with an asynchronous reset.
  task automatic reset_mid_pulse();
    address = 2'b00;
    writedata = 8'hE7;
    wr[0] = 1'b1;
    for (int k = 0; k < T_AS + 1 + 5; k++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("pulse_before_reset", 32'(e[0]), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check("reset_e_async", 32'(e[0]), 32'(0));
    check("reset_oe_async", 32'(oe[0]), 32'(0));
    check("reset_rw_async", 32'(rw[0]), 32'(1));
    wr[0] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int s = 0; s < 2; s++) begin
      last_e[s] = 1'b0;
      last_fall[s] = -1;
    end
  endtask

  initial begin
    reset = 1'b1;
    address = '0;
    writedata = '0;
    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0;
      wr[s] = 1'b0;
      din[s] = '0;
      exp_rd[s] = '0;
      last_e[s] = 1'b0;
      last_fall[s] = -1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_e", 32'(e[s]), 32'(0));
      check("rst_rs", 32'(rs[s]), 32'(0));
      check("rst_rw", 32'(rw[s]), 32'(1));
      check("rst_oe", 32'(oe[s]), 32'(0));
      check("rst_readdata", 32'(rdata[s]), 32'(0));
      check("rst_waitrequest", 32'(wreq[s]), 32'(0));
    end
    check("rst_data8", 32'(dout8), 32'(0));
    check("rst_data4", 32'(dout4), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    xfer(0, 1'b0, 1'b1, 2'b10, 8'h41);  // data write
    xfer(0, 1'b1, 1'b0, 2'b01, 8'h00);  // status read
    xfer(1, 1'b0, 1'b1, 2'b00, 8'h3C);  // nibble-mode command write
    xfer(1, 1'b1, 1'b0, 2'b01, 8'h00);  // nibble-mode read
    xfer(0, 1'b0, 1'b1, 2'b00, 8'h01);  // back-to-back pair
    xfer(0, 1'b0, 1'b1, 2'b00, 8'h02);
    xfer(0, 1'b1, 1'b1, 2'b10, 8'h5A);  // read+write acts as write
    xfer(1, 1'b0, 1'b1, 2'b01, 8'hC3);  // write with RW=1: no capture

    reset_mid_pulse();
    xfer(0, 1'b0, 1'b1, 2'b10, 8'h99);  // full-length cycle after abort

    for (int i = 0; i < 12; i++) begin
      logic rw_rand;
      rw_rand = 1'($urandom);
      xfer(int'($urandom_range(0, 1)), rw_rand, ~rw_rand, 2'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
